// File: rtl/int_flag_shadow.sv
// int_flag_shadow
// Interrupt-side companion to the MCU flag register.
// - Synchronises an external interrupt line and detects its rising edge.
// - Latches the edge into a sticky pending bit.
// - Presents a request gated by the I flag and by the IDLE state.
// - Saves C/Z on acknowledge and replays them with a one-cycle restore strobe on RETI.
// Optional feature: define INT_OVERRUN_EN to build the sticky overrun indicator.
// Without that macro, INT_OVR is tied low and no overrun logic is built.
// SYNC_STAGES must be in the range 2 to 4.

module int_flag_shadow #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic INTR,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INT_ACK,
    input  logic RETI,
    input  logic RETI_IE,
    input  logic C_FLG,
    input  logic Z_FLG,
    output logic INT_REQ,
    output logic I_FLG,
    output logic SHAD_C,
    output logic SHAD_Z,
    output logic FLG_RESTORE,
    output logic INT_OVR
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_pend;
    logic                   r_i_flg;
    logic                   r_shad_c;
    logic                   r_shad_z;
    logic                   r_flg_restore;
    logic                   w_edge;
    logic                   w_int_req;
    logic                   w_accept;
    logic                   w_return;

    // Synchroniser chain: stage 0 samples the raw line, and each later stage follows the one before it.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage captures the asynchronous input
                always_ff @(posedge CLK) begin
                    if (RST) r_sync[gi] <= 1'b0;
                    else     r_sync[gi] <= INTR;
                end
            end else begin : g_rest
                // Later stages shift the sample along the chain
                always_ff @(posedge CLK) begin
                    if (RST) r_sync[gi] <= 1'b0;
                    else     r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    // History flop holds the previous synchronised value for edge detection
    always_ff @(posedge CLK) begin
        if (RST) r_hist <= 1'b0;
        else     r_hist <= r_sync[SYNC_STAGES-1];
    end

    assign w_edge    = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_int_req = r_pend & r_i_flg & (r_state == ST_IDLE);

    // Next state and acceptance qualifiers; ACK only counts while a request is shown
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_return     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (INT_ACK && w_int_req) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (RETI) begin
                    w_return     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Sticky pending bit; a fresh edge beats the clear from a simultaneous acknowledge
    always_ff @(posedge CLK) begin
        if (RST)           r_pend <= 1'b0;
        else if (w_edge)   r_pend <= 1'b1;
        else if (w_accept) r_pend <= 1'b0;
    end

    // I flag: the ACK clear and the RETI load override SEI/CLI, and CLI beats SEI
    always_ff @(posedge CLK) begin
        if (RST)           r_i_flg <= 1'b0;
        else if (w_accept) r_i_flg <= 1'b0;
        else if (w_return) r_i_flg <= RETI_IE;
        else if (I_CLR)    r_i_flg <= 1'b0;
        else if (I_SET)    r_i_flg <= 1'b1;
    end

    // Shadow flags are captured only when an interrupt is accepted
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shad_c <= 1'b0;
            r_shad_z <= 1'b0;
        end else if (w_accept) begin
            r_shad_c <= C_FLG;
            r_shad_z <= Z_FLG;
        end
    end

    // Restore strobe lasts one cycle, because the state is IDLE after each RETI
    always_ff @(posedge CLK) begin
        if (RST) r_flg_restore <= 1'b0;
        else     r_flg_restore <= w_return;
    end

`ifdef INT_OVERRUN_EN
    logic r_ovr;

    // Overrun: an edge that arrives while a request is still pending; a same-cycle ACK clear loses
    always_ff @(posedge CLK) begin
        if (RST)                  r_ovr <= 1'b0;
        else if (w_edge && r_pend) r_ovr <= 1'b1;
        else if (w_accept)         r_ovr <= 1'b0;
    end

    assign INT_OVR = r_ovr;
`else
    assign INT_OVR = 1'b0;
`endif

    assign INT_REQ     = w_int_req;
    assign I_FLG       = r_i_flg;
    assign SHAD_C      = r_shad_c;
    assign SHAD_Z      = r_shad_z;
    assign FLG_RESTORE = r_flg_restore;

endmodule

// File: tb/tb_int_flag_shadow.sv
// Testbench for int_flag_shadow.
// A reference model computes the expected outputs after every rising edge and pushes them into a queue.
// A separate monitor pops each entry and compares it with the DUT outputs.
`timescale 1ns/1ps

module tb_int_flag_shadow;

    localparam int S     = 2;
    localparam int MAXC  = 4000;

    logic CLK = 1'b0;
    logic RST, INTR, I_SET, I_CLR, INT_ACK, RETI, RETI_IE, C_FLG, Z_FLG;
    logic INT_REQ, I_FLG, SHAD_C, SHAD_Z, FLG_RESTORE, INT_OVR;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int   cyc;
        logic req;
        logic ie;
        logic shc;
        logic shz;
        logic rest;
        logic ovr;
    } exp_t;

    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    int_flag_shadow #(.SYNC_STAGES(S)) dut (
        .CLK(CLK), .RST(RST), .INTR(INTR), .I_SET(I_SET), .I_CLR(I_CLR),
        .INT_ACK(INT_ACK), .RETI(RETI), .RETI_IE(RETI_IE), .C_FLG(C_FLG), .Z_FLG(Z_FLG),
        .INT_REQ(INT_REQ), .I_FLG(I_FLG), .SHAD_C(SHAD_C), .SHAD_Z(SHAD_Z),
        .FLG_RESTORE(FLG_RESTORE), .INT_OVR(INT_OVR)
    );

    // Model state. An edge is derived from the INTR samples taken at each clock edge:
    // when INTR is high at edge m and was low at edge m-1, pending sets at edge m+S.
    // Samples taken at or before a reset edge count as low.
    logic samp [0:MAXC];
    int   cyc     = 0;
    int   rst_cyc = 0;
    bit   m_svc, m_pend, m_ie, m_shc, m_shz, m_rest, m_ovr;

    function automatic bit edge_at(int n);
        int  j;
        bit  cur, prev;
        j = n - S;
        if (j <= rst_cyc || j < 1) return 1'b0;
        cur  = samp[j];
        prev = ((j - 1) <= rst_cyc) ? 1'b0 : samp[j-1];
        return cur && !prev;
    endfunction

    task automatic model_step();
        bit   e, req, acc, ret;
        exp_t x;
        cyc++;
        samp[cyc] = INTR;
        if (RST) begin
            rst_cyc = cyc;
            m_svc = 0; m_pend = 0; m_ie = 0; m_shc = 0; m_shz = 0; m_rest = 0; m_ovr = 0;
        end else begin
            e   = edge_at(cyc);
            req = m_pend && m_ie && !m_svc;
            acc = INT_ACK && req;
            ret = RETI && m_svc;
`ifdef INT_OVERRUN_EN
            if (e && m_pend) m_ovr = 1;
            else if (acc)    m_ovr = 0;
`else
            m_ovr = 0;
`endif
            m_rest = ret;
            if (acc) begin
                m_shc = C_FLG; m_shz = Z_FLG; m_ie = 0; m_svc = 1;
            end else if (ret) begin
                m_ie = RETI_IE; m_svc = 0;
            end else if (I_CLR) begin
                m_ie = 0;
            end else if (I_SET) begin
                m_ie = 1;
            end
            if (e)        m_pend = 1;
            else if (acc) m_pend = 0;
        end
        x.cyc  = cyc;
        x.req  = m_pend && m_ie && !m_svc;
        x.ie   = m_ie;
        x.shc  = m_shc;
        x.shz  = m_shz;
        x.rest = m_rest;
        x.ovr  = m_ovr;
        exp_q.push_back(x);
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    task automatic check(input string name, input int c, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL cycle %0d %s: got %b expected %b", c, name, got, exp);
        end
    endtask

    // Monitor: sample 1 ns after each rising edge and compare the outputs with the next queued expectation
    initial begin
        exp_t x;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard: got empty queue expected an entry");
            end else begin
                x = exp_q.pop_front();
                check("INT_REQ",     x.cyc, INT_REQ,     x.req);
                check("I_FLG",       x.cyc, I_FLG,       x.ie);
                check("SHAD_C",      x.cyc, SHAD_C,      x.shc);
                check("SHAD_Z",      x.cyc, SHAD_Z,      x.shz);
                check("FLG_RESTORE", x.cyc, FLG_RESTORE, x.rest);
                check("INT_OVR",     x.cyc, INT_OVR,     x.ovr);
                $display("cycle %0d req=%b ie=%b shc=%b shz=%b rest=%b ovr=%b",
                         x.cyc, INT_REQ, I_FLG, SHAD_C, SHAD_Z, FLG_RESTORE, INT_OVR);
            end
        end
    end

    // Drive one cycle of inputs on the falling edge
    task automatic drive(input logic rst, input logic intr, input logic iset, input logic iclr,
                         input logic ack, input logic reti, input logic rie,
                         input logic c, input logic z);
        @(negedge CLK);
        RST = rst; INTR = intr; I_SET = iset; I_CLR = iclr; INT_ACK = ack;
        RETI = reti; RETI_IE = rie; C_FLG = c; Z_FLG = z;
    endtask

    initial begin
        logic intr_lvl;
        RST = 1; INTR = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0;
        RETI = 0; RETI_IE = 0; C_FLG = 0; Z_FLG = 0;
        // Directed walk through the main scenarios; the model supplies every expectation
        //         rst intr set clr ack reti rie c z
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 1, 0, 0, 1, 0);                  // acknowledge with C=1, Z=0
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);                  // live flags change; shadows hold
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 0, 0, 1); // edge during SERVICE
        drive(0, 1, 0, 0, 1, 0, 0, 0, 0);                  // ACK during SERVICE is ignored
        drive(0, 1, 0, 0, 0, 1, 1, 0, 0);                  // RETIE
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);                  // RETI in IDLE is ignored
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 0, 0, 0); // third edge before ACK
        drive(0, 1, 1, 0, 1, 0, 0, 0, 1);                  // ACK with I_SET high
        drive(0, 1, 1, 1, 0, 0, 0, 0, 0);                  // SEI and CLI together
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);                  // RETID
        drive(0, 0, 0, 0, 1, 0, 0, 1, 1);                  // ACK without a request
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 0, 0, 0); // pending while in SERVICE
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);                  // reset mid-service
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Randomised phase
        intr_lvl = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 5) == 0) intr_lvl = ~intr_lvl;
            drive($urandom_range(0, 299) == 0, intr_lvl,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
